gsu_mem_arbiter: RTL and testbench

- Shares the single external ROM/SRAM port between three requesters: SNES, MCU and GSU.
- The SNES request is qualified upstream by the address decoder (ROM_HIT / IS_WRITABLE), and the address arrives already translated to the physical address.
- The arbiter sequences one fixed-length memory access at a time and returns read data with a one-cycle acknowledge pulse.
- SNES has absolute priority; MCU and GSU alternate round-robin.

---
 rtl/gsu_mem_pkg.sv | 18 +
 rtl/gsu_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_gsu_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsu_mem_pkg.sv
// Shared constants and types for the GSU memory-port arbiter.
// Grant encodings, FSM states and the access-counter width.
package gsu_mem_pkg;

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_SNES = 2'd1;
    localparam logic [1:0] GRANT_MCU  = 2'd2;
    localparam logic [1:0] GRANT_GSU  = 2'd3;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/gsu_mem_arbiter.sv
// Three-way arbiter for the single external ROM/SRAM port: SNES has absolute
// priority, MCU and GSU share round-robin; one fixed-length access at a time.
module gsu_mem_arbiter
    import gsu_mem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 4,
    parameter int ADDR_W        = 24,
    parameter int DATA_W        = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              snes_req,
    input  logic              snes_we,
    input  logic              snes_writable,
    input  logic [ADDR_W-1:0] snes_addr,
    input  logic [DATA_W-1:0] snes_wdata,
    output logic              snes_ack,
    output logic [DATA_W-1:0] snes_rdata,
    input  logic              mcu_req,
    input  logic              mcu_we,
    input  logic [ADDR_W-1:0] mcu_addr,
    input  logic [DATA_W-1:0] mcu_wdata,
    output logic              mcu_ack,
    output logic [DATA_W-1:0] mcu_rdata,
    input  logic              gsu_req,
    input  logic              gsu_we,
    input  logic [ADDR_W-1:0] gsu_addr,
    input  logic [DATA_W-1:0] gsu_wdata,
    output logic              gsu_ack,
    output logic [DATA_W-1:0] gsu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [1:0]        grant_id
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;      // access is a write (no read capture)
    logic                wen_q, wen_d;    // write strobe actually allowed
    logic                rr_q, rr_d;      // 0: MCU next, 1: GSU next
    logic [DATA_W-1:0]   snes_rdata_q, snes_rdata_d;
    logic [DATA_W-1:0]   mcu_rdata_q, mcu_rdata_d;
    logic [DATA_W-1:0]   gsu_rdata_q, gsu_rdata_d;

    logic [1:0]          sel;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Requester selection and mux, evaluated every cycle but used only in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel       = GRANT_NONE;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (snes_req) begin
            sel = GRANT_SNES;
        end else if (mcu_req && gsu_req) begin
            sel = rr_q ? GRANT_GSU : GRANT_MCU;
        end else if (mcu_req) begin
            sel = GRANT_MCU;
        end else if (gsu_req) begin
            sel = GRANT_GSU;
        end
        case (sel)
            GRANT_SNES: begin sel_we = snes_we; sel_addr = snes_addr; sel_wdata = snes_wdata; end
            GRANT_MCU:  begin sel_we = mcu_we;  sel_addr = mcu_addr;  sel_wdata = mcu_wdata;  end
            GRANT_GSU:  begin sel_we = gsu_we;  sel_addr = gsu_addr;  sel_wdata = gsu_wdata;  end
            default:    ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (sel != GRANT_NONE) state_d = ST_ACCESS;
            ST_ACCESS: if (cnt_q == '0)       state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: strobes only during ACCESS, ack only during FINISH.
    always_comb begin
        mem_ce   = (state_q == ST_ACCESS);
        mem_oe   = mem_ce && !wr_q;
        mem_we   = mem_ce && wen_q;
        snes_ack = (state_q == ST_FINISH) && (grant_q == GRANT_SNES);
        mcu_ack  = (state_q == ST_FINISH) && (grant_q == GRANT_MCU);
        gsu_ack  = (state_q == ST_FINISH) && (grant_q == GRANT_GSU);
    end

    // Datapath next-state: latch the winner, count the access, capture read data.
    always_comb begin
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        wen_d        = wen_q;
        rr_d         = rr_q;
        snes_rdata_d = snes_rdata_q;
        mcu_rdata_d  = mcu_rdata_q;
        gsu_rdata_d  = gsu_rdata_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = sel;
                if (sel != GRANT_NONE) begin
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wr_d    = sel_we;
                    // Unwritable SNES writes run full length with no strobe at all.
                    wen_d   = sel_we && ((sel != GRANT_SNES) || snes_writable);
                    cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!wr_q) begin
                    case (grant_q)
                        GRANT_SNES: snes_rdata_d = mem_rdata;
                        GRANT_MCU:  mcu_rdata_d  = mem_rdata;
                        GRANT_GSU:  gsu_rdata_d  = mem_rdata;
                        default:    ;
                    endcase
                end
            end
            ST_FINISH: begin
                grant_d = GRANT_NONE;
                if (grant_q == GRANT_MCU || grant_q == GRANT_GSU) rr_d = !rr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q        <= '0;
            grant_q      <= GRANT_NONE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            wen_q        <= 1'b0;
            rr_q         <= 1'b0;
            snes_rdata_q <= '0;
            mcu_rdata_q  <= '0;
            gsu_rdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            wen_q        <= wen_d;
            rr_q         <= rr_d;
            snes_rdata_q <= snes_rdata_d;
            mcu_rdata_q  <= mcu_rdata_d;
            gsu_rdata_q  <= gsu_rdata_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign grant_id   = grant_q;
    assign snes_rdata = snes_rdata_q;
    assign mcu_rdata  = mcu_rdata_q;
    assign gsu_rdata  = gsu_rdata_q;

endmodule

// File: tb/tb_gsu_mem_arbiter.sv
// Directed bench for gsu_mem_arbiter: a table of single accesses plus
// hand-written sequences for priority, round-robin, no-pre-emption and reset.
module tb_gsu_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        snes_req, snes_we, snes_writable;
    logic [23:0] snes_addr;
    logic [7:0]  snes_wdata;
    logic        snes_ack;
    logic [7:0]  snes_rdata;
    logic        mcu_req, mcu_we;
    logic [23:0] mcu_addr;
    logic [7:0]  mcu_wdata;
    logic        mcu_ack;
    logic [7:0]  mcu_rdata;
    logic        gsu_req, gsu_we;
    logic [23:0] gsu_addr;
    logic [7:0]  gsu_wdata;
    logic        gsu_ack;
    logic [7:0]  gsu_rdata;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ce, mem_we, mem_oe;
    logic [1:0]  grant_id;

    // Second instance with the shortest legal access length.
    logic        mcu_req_1;
    logic [7:0]  mem_rdata_1;
    logic        snes_ack_1, mcu_ack_1, gsu_ack_1;
    logic [7:0]  snes_rdata_1, mcu_rdata_1, gsu_rdata_1;
    logic [23:0] mem_addr_1;
    logic [7:0]  mem_wdata_1;
    logic        mem_ce_1, mem_we_1, mem_oe_1;
    logic [1:0]  grant_id_1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    gsu_mem_arbiter #(.ACCESS_CYCLES(4), .ADDR_W(24), .DATA_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .snes_req(snes_req), .snes_we(snes_we), .snes_writable(snes_writable),
        .snes_addr(snes_addr), .snes_wdata(snes_wdata), .snes_ack(snes_ack), .snes_rdata(snes_rdata),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
        .mcu_ack(mcu_ack), .mcu_rdata(mcu_rdata),
        .gsu_req(gsu_req), .gsu_we(gsu_we), .gsu_addr(gsu_addr), .gsu_wdata(gsu_wdata),
        .gsu_ack(gsu_ack), .gsu_rdata(gsu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_oe(mem_oe), .grant_id(grant_id)
    );

    gsu_mem_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(24), .DATA_W(8)) dut_1 (
        .CLK(CLK), .RST(RST),
        .snes_req(1'b0), .snes_we(1'b0), .snes_writable(1'b0),
        .snes_addr(24'h0), .snes_wdata(8'h0), .snes_ack(snes_ack_1), .snes_rdata(snes_rdata_1),
        .mcu_req(mcu_req_1), .mcu_we(1'b0), .mcu_addr(mcu_addr), .mcu_wdata(8'h0),
        .mcu_ack(mcu_ack_1), .mcu_rdata(mcu_rdata_1),
        .gsu_req(1'b0), .gsu_we(1'b0), .gsu_addr(24'h0), .gsu_wdata(8'h0),
        .gsu_ack(gsu_ack_1), .gsu_rdata(gsu_rdata_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1),
        .mem_ce(mem_ce_1), .mem_we(mem_we_1), .mem_oe(mem_oe_1), .grant_id(grant_id_1)
    );

    typedef struct {
        logic [1:0]  id;
        logic        we;
        logic        wrt;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  mrd;
        logic        exp_oe;
        logic        exp_we;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] id);
        case (id)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] acks();
        return {snes_ack, mcu_ack, gsu_ack};
    endfunction

    function automatic logic [7:0] rdata_of(input logic [1:0] id);
        case (id)
            2'd1:    return snes_rdata;
            2'd2:    return mcu_rdata;
            2'd3:    return gsu_rdata;
            default: return 8'h00;
        endcase
    endfunction

    task automatic clear_reqs();
        snes_req = 1'b0; mcu_req = 1'b0; gsu_req = 1'b0; mcu_req_1 = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] id, input logic we, input logic wrt,
                           input logic [23:0] addr, input logic [7:0] wdata);
        case (id)
            2'd1: begin snes_req = 1'b1; snes_we = we; snes_writable = wrt;
                        snes_addr = addr; snes_wdata = wdata; end
            2'd2: begin mcu_req = 1'b1; mcu_we = we; mcu_addr = addr; mcu_wdata = wdata; end
            2'd3: begin gsu_req = 1'b1; gsu_we = we; gsu_addr = addr; gsu_wdata = wdata; end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        logic [1:0] order[$];
        int         ack_cyc[$];
        int         cyc;
        logic [2:0] reassert;
        vec_t       v;

        clear_reqs();
        snes_we = 0; snes_writable = 0; snes_addr = 0; snes_wdata = 0;
        mcu_we = 0; mcu_addr = 0; mcu_wdata = 0;
        gsu_we = 0; gsu_addr = 0; gsu_wdata = 0;
        mem_rdata = 0; mem_rdata_1 = 0;
        RST = 1'b1;
        tick();
        do_reset();

        check("reset_acks",   {29'd0, acks()}, 32'd0);
        check("reset_strobe", {29'd0, mem_ce, mem_we, mem_oe}, 32'd0);
        check("reset_grant",  grant_id, 32'd0);
        check("reset_addr",   mem_addr, 32'd0);
        check("reset_wdata",  mem_wdata, 32'd0);
        check("reset_rdata",  {8'd0, snes_rdata, mcu_rdata, gsu_rdata}, 32'd0);

        //           id    we    wrt   addr         wdata  mrd    oe    we    rdata
        vecs[0] = '{2'd2, 1'b0, 1'b0, 24'h012345, 8'h00, 8'hA5, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{2'd1, 1'b1, 1'b1, 24'hE00010, 8'h3C, 8'h11, 1'b0, 1'b1, 8'h00};
        vecs[2] = '{2'd1, 1'b1, 1'b0, 24'hE00010, 8'h3C, 8'h22, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{2'd1, 1'b0, 1'b1, 24'h400000, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h5A};
        vecs[4] = '{2'd3, 1'b0, 1'b0, 24'h700123, 8'h00, 8'hC3, 1'b1, 1'b0, 8'hC3};
        vecs[5] = '{2'd3, 1'b1, 1'b0, 24'h700124, 8'h99, 8'h12, 1'b0, 1'b1, 8'hC3};
        vecs[6] = '{2'd2, 1'b1, 1'b0, 24'h001000, 8'h11, 8'hFF, 1'b0, 1'b1, 8'hA5};
        vecs[7] = '{2'd1, 1'b1, 1'b0, 24'hE00020, 8'h66, 8'hEE, 1'b0, 1'b0, 8'h5A};

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            mem_rdata = v.mrd;
            set_req(v.id, v.we, v.wrt, v.addr, v.wdata);
            tick();
            check($sformatf("v%0d_grant", i), grant_id, v.id);
            for (int c = 0; c < 4; c++) begin
                check($sformatf("v%0d_c%0d_ce", i, c), mem_ce, 1'b1);
                check($sformatf("v%0d_c%0d_oe", i, c), mem_oe, v.exp_oe);
                check($sformatf("v%0d_c%0d_we", i, c), mem_we, v.exp_we);
                check($sformatf("v%0d_c%0d_addr", i, c), mem_addr, v.addr);
                check($sformatf("v%0d_c%0d_wdata", i, c), mem_wdata, v.wdata);
                check($sformatf("v%0d_c%0d_noack", i, c), acks(), 3'b000);
                tick();
            end
            check($sformatf("v%0d_ack", i), acks(), onehot(v.id));
            check($sformatf("v%0d_fin_strobe", i), {mem_ce, mem_we, mem_oe}, 3'b000);
            check($sformatf("v%0d_fin_grant", i), grant_id, v.id);
            check($sformatf("v%0d_rdata", i), rdata_of(v.id), v.exp_rd);
            clear_reqs();
            tick();
            check($sformatf("v%0d_idle_grant", i), grant_id, 2'd0);
            check($sformatf("v%0d_idle_ack", i), acks(), 3'b000);
        end

        // All three requesters raised together: SNES, MCU, GSU, 6 cycles apart.
        do_reset();
        mem_rdata = 8'h5C;
        set_req(2'd1, 1'b0, 1'b1, 24'h000100, 8'h00);
        set_req(2'd2, 1'b0, 1'b0, 24'h000200, 8'h00);
        set_req(2'd3, 1'b0, 1'b0, 24'h000300, 8'h00);
        cyc = 0;
        while (order.size() < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (acks() != 3'b000) begin
                check("all3_ack_owner", acks(), onehot(grant_id));
                order.push_back(grant_id);
                ack_cyc.push_back(cyc);
                case (grant_id)
                    2'd1: snes_req = 1'b0;
                    2'd2: mcu_req  = 1'b0;
                    2'd3: gsu_req  = 1'b0;
                    default: ;
                endcase
            end
        end
        check("all3_count", order.size(), 3);
        if (order.size() == 3) begin
            check("all3_first",  order[0], 2'd1);
            check("all3_second", order[1], 2'd2);
            check("all3_third",  order[2], 2'd3);
            check("all3_lat",    ack_cyc[0], 5);
            check("all3_gap1",   ack_cyc[1] - ack_cyc[0], 6);
            check("all3_gap2",   ack_cyc[2] - ack_cyc[1], 6);
        end
        clear_reqs();
        tick();

        // MCU and GSU continuously re-requesting alternate from MCU.
        do_reset();
        order.delete();
        set_req(2'd2, 1'b0, 1'b0, 24'h000010, 8'h00);
        set_req(2'd3, 1'b0, 1'b0, 24'h000020, 8'h00);
        reassert = 3'b000;
        cyc = 0;
        while (order.size() < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (reassert[1]) mcu_req = 1'b1;
            if (reassert[0]) gsu_req = 1'b1;
            reassert = 3'b000;
            if (acks() != 3'b000) begin
                order.push_back(grant_id);
                if (grant_id == 2'd2) begin mcu_req = 1'b0; reassert[1] = 1'b1; end
                if (grant_id == 2'd3) begin gsu_req = 1'b0; reassert[0] = 1'b1; end
            end
        end
        check("rr_count", order.size(), 4);
        if (order.size() == 4) begin
            check("rr_0", order[0], 2'd2);
            check("rr_1", order[1], 2'd3);
            check("rr_2", order[2], 2'd2);
            check("rr_3", order[3], 2'd3);
        end
        clear_reqs();
        tick();

        // SNES arriving mid-GSU access waits, then wins the next IDLE.
        do_reset();
        mem_rdata = 8'h77;
        set_req(2'd3, 1'b0, 1'b0, 24'h700000, 8'h00);
        tick();
        tick();
        set_req(2'd1, 1'b0, 1'b1, 24'h123456, 8'h00);
        cyc = 0;
        while (acks() == 3'b000 && cyc < 10) begin
            tick();
            cyc++;
        end
        check("nopre_gsu_ack", acks(), 3'b001);
        check("nopre_gsu_grant", grant_id, 2'd3);
        gsu_req = 1'b0;
        tick();
        check("nopre_idle_grant", grant_id, 2'd0);
        tick();
        check("nopre_snes_grant", grant_id, 2'd1);
        check("nopre_snes_addr", mem_addr, 24'h123456);
        cyc = 0;
        while (acks() == 3'b000 && cyc < 10) begin
            tick();
            cyc++;
        end
        check("nopre_snes_ack", acks(), 3'b100);
        check("nopre_snes_rdata", snes_rdata, 8'h77);
        clear_reqs();
        tick();

        // Reset in the 3rd ACCESS cycle of an MCU read aborts without ack.
        do_reset();
        mem_rdata = 8'h42;
        set_req(2'd2, 1'b0, 1'b0, 24'h0ABCDE, 8'h00);
        tick();
        tick();
        tick();
        check("rst_pre_oe", mem_oe, 1'b1);
        RST = 1'b1;
        tick();
        check("rst_strobe", {mem_ce, mem_we, mem_oe}, 3'b000);
        check("rst_grant", grant_id, 2'd0);
        check("rst_noack", acks(), 3'b000);
        check("rst_addr", mem_addr, 24'h0);
        check("rst_rdata", mcu_rdata, 8'h00);
        RST = 1'b0;
        tick();
        check("rst_regrant", grant_id, 2'd2);
        cyc = 0;
        while (acks() == 3'b000 && cyc < 10) begin
            tick();
            cyc++;
        end
        check("rst_ack", acks(), 3'b010);
        check("rst_ack_lat", cyc, 4);
        check("rst_rdata_after", mcu_rdata, 8'h42);
        clear_reqs();
        tick();

        // ACCESS_CYCLES=1: one ACCESS cycle, ack the next.
        mcu_addr = 24'h000055;
        mem_rdata_1 = 8'h3E;
        mcu_req_1 = 1'b1;
        tick();
        check("ac1_grant", grant_id_1, 2'd2);
        check("ac1_strobe", {mem_ce_1, mem_we_1, mem_oe_1}, 3'b101);
        check("ac1_addr", mem_addr_1, 24'h000055);
        check("ac1_noack", {snes_ack_1, mcu_ack_1, gsu_ack_1}, 3'b000);
        tick();
        check("ac1_ack", {snes_ack_1, mcu_ack_1, gsu_ack_1}, 3'b010);
        check("ac1_fin_strobe", {mem_ce_1, mem_we_1, mem_oe_1}, 3'b000);
        check("ac1_rdata", mcu_rdata_1, 8'h3E);
        mcu_req_1 = 1'b0;
        tick();
        check("ac1_idle_grant", grant_id_1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
